fp32_div_seq: RTL

- Sequential IEEE-754 single-precision divider; the inverse operation of the team's shift-add multiplier in the same arithmetic datapath.
- Computes flt_out = flt_A / flt_B using a one-bit-per-cycle restoring mantissa division, with exponent subtraction and round-to-nearest.
- Start/done handshake with fixed latency; result is held until the next operation completes.

---
 rtl/fp32_div_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division one
// quotient bit per clock, exponent subtraction, round-half-away on one guard bit.
module fp32_div_seq (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [31:0] flt_A,
  input  logic [31:0] flt_B,
  output logic        busy,
  output logic        done,
  output logic [31:0] flt_out,
  output logic        div_zero,
  output logic        ovf,
  output logic        unf
);

  localparam int QBITS = 26;
  localparam int BIAS  = 127;

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse and
  // flt_out/flags stay valid from done until the next done.
  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             state, state_nxt;
  logic               sign;
  logic               zero_a, zero_b;
  logic [23:0]        mb;
  logic [24:0]        rem;
  logic [25:0]        q;
  logic [4:0]         count;
  logic signed [9:0]  e;
  logic [22:0]        frac;

  logic [25:0]        trial;
  logic [24:0]        rem_nxt;
  logic [23:0]        mant_sel;
  logic               rnd;
  logic [24:0]        mant_rnd;
  logic signed [9:0]  e_norm;
  logic signed [9:0]  e_fix;
  logic [22:0]        frac_fix;
  logic               unused_lead;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIVIDE;
      DIVIDE:  if (count == 5'(QBITS - 1)) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trial subtraction; bit 25 set means the remainder was smaller than mB.
  always_comb begin
    trial   = {1'b0, rem} - {2'b00, mb};
    rem_nxt = trial[25] ? rem : trial[24:0];
  end

  // Normalise on the leading quotient bit, then round using the next bit.
  always_comb begin
    if (q[25]) begin
      mant_sel = q[25:2];
      rnd      = q[1];
      e_norm   = e;
    end else begin
      mant_sel = q[24:1];
      rnd      = q[0];
      e_norm   = e - 10'sd1;
    end
    mant_rnd = {1'b0, mant_sel} + {24'b0, rnd};
    if (mant_rnd[24]) begin
      frac_fix = 23'b0;
      e_fix    = e_norm + 10'sd1;
    end else begin
      frac_fix = mant_rnd[22:0];
      e_fix    = e_norm;
    end
  end

  assign unused_lead = mant_rnd[23];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      flt_out  <= 32'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      sign     <= 1'b0;
      zero_a   <= 1'b0;
      zero_b   <= 1'b0;
      mb       <= 24'b0;
      rem      <= 25'b0;
      q        <= 26'b0;
      count    <= 5'b0;
      e        <= 10'sd0;
      frac     <= 23'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy   <= 1'b1;
          sign   <= flt_A[31] ^ flt_B[31];
          zero_a <= (flt_A[30:23] == 8'd0);
          zero_b <= (flt_B[30:23] == 8'd0);
          rem    <= {2'b01, flt_A[22:0]};
          mb     <= {1'b1, flt_B[22:0]};
          e      <= $signed({2'b00, flt_A[30:23]}) - $signed({2'b00, flt_B[30:23]})
                    + 10'(BIAS);
          q      <= 26'b0;
          count  <= 5'b0;
        end
        DIVIDE: begin
          rem   <= rem_nxt << 1;
          q     <= {q[24:0], ~trial[25]};
          count <= count + 5'd1;
        end
        NORM: begin
          e    <= e_fix;
          frac <= frac_fix;
        end
        DONE: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= 1'b0;
          ovf      <= 1'b0;
          unf      <= 1'b0;
          if (zero_b) begin
            flt_out  <= {sign, 8'hFF, 23'b0};
            div_zero <= 1'b1;
          end else if (zero_a) begin
            flt_out <= {sign, 31'b0};
          end else if (e >= 10'sd255) begin
            flt_out <= {sign, 8'hFF, 23'b0};
            ovf     <= 1'b1;
          end else if (e <= 10'sd0) begin
            flt_out <= {sign, 31'b0};
            unf     <= 1'b1;
          end else begin
            flt_out <= {sign, e[7:0], frac};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
